// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory line port.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    WR_WAIT = 2'b10,
    RESP    = 2'b11
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-storage RAM: synchronous byte-enabled write, combinational line-wide read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned WA_W       = 10,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [WA_W-1:0]          waddr,
  input  logic [31:0]              wdata,
  input  logic [WORD_BYTES-1:0]    wbe,
  input  logic [WA_W-1:0]          raddr,
  output logic [LINE_WORDS*32-1:0] rline
);

  logic [31:0] mem [0:(1<<WA_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < WORD_BYTES; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // raddr is line-aligned, so OR-ing in the word offset never carries
  always_comb begin
    rline = '0;
    for (int unsigned k = 0; k < LINE_WORDS; k++) begin
      rline[32*k +: 32] = mem[raddr | WA_W'(k)];
    end
  end

endmodule

// File: rtl/dmem_line_port.sv
// Fixed-latency backing memory: line reads, word write-through stores, ready pulse.
// Optional macro DMEM_BYTE_STROBE_EN enables per-byte write merging via wstrb.
module dmem_line_port
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dm_re,
  input  logic                     dm_we,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  output logic [LINE_WORDS*32-1:0] rline,
  output logic                     ready,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned WA_W  = ADDR_W - 2;
  localparam int unsigned CNT_W = (clog2(LATENCY) > 0) ? clog2(LATENCY) : 1;
  localparam logic [WA_W-1:0]  LINE_MASK = WA_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(LATENCY - 1);

  if (LATENCY < 1) begin : g_bad_latency
    $error("dmem_line_port: LATENCY must be >= 1");
  end
  if ((LINE_WORDS == 0) || ((LINE_WORDS & (LINE_WORDS - 1)) != 0)) begin : g_bad_line
    $error("dmem_line_port: LINE_WORDS must be a power of 2");
  end

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WA_W-1:0]         addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [LINE_WORDS*32-1:0] rline_q, rline_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;

  logic                    mem_we;
  logic [3:0]              mem_wbe;
  logic [LINE_WORDS*32-1:0] arr_rline;
  logic [WA_W-1:0]         word_idx;
  logic                    unused_inputs;

  assign word_idx = addr[ADDR_W-1:2];

`ifdef DMEM_BYTE_STROBE_EN
  assign mem_wbe       = wstrb_q;
  assign unused_inputs = ^addr[1:0];
`else
  assign mem_wbe       = '1;
  assign unused_inputs = ^{addr[1:0], wstrb_q};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rline_d = rline_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dm_re && !dm_we) begin
          addr_d  = word_idx & ~LINE_MASK;
          cnt_d   = CNT_INIT;
          state_d = RD_WAIT;
        end else if (dm_we && !dm_re) begin
          addr_d  = word_idx;
          wdata_d = wdata;
          wstrb_d = wstrb;
          cnt_d   = CNT_INIT;
          state_d = WR_WAIT;
        end else if (dm_we && dm_re) begin
          err_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rline_d = arr_rline;
          ready_d = 1'b1;
          state_d = RESP;
        end
      end
      WR_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mem_we  = 1'b1;
          ready_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rline_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rline_q <= rline_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(
    .WA_W       (WA_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .wbe   (mem_wbe),
    .raddr (addr_q),
    .rline (arr_rline)
  );

  assign rline = rline_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule
